aes_inv_cipher: RTL
===================

# aes_inv_cipher

Iterative AES-128 decryption core, the inverse of the existing `TOP` encryption core. It pairs with `TOP` on the same `valid_in`/`valid_out` pulse protocol. It accepts a 128-bit ciphertext and cipher key, runs the forward key expansion to reach the last round key, then executes the FIPS-197 inverse cipher at one round per clock with an on-the-fly inverse key schedule. It sits beside `TOP` in the crypto datapath, so that `TOP` output fed here returns the original plaintext.

## Interface
- `KEY_LEN`, default 128: key width. Only 128 is supported.
- `DATA_LEN`, default 128: block width. Only 128 is supported.
- `NUMS_OF_ROUND`, default 10: number of cipher rounds. Only 10 is supported.
- `clk`, in, 1: the single clock. Everything is on the rising edge.
- `reset`, in, 1: synchronous, active-low reset. `reset`=0 at a rising edge resets the block.
- `data_valid_in`, in, 1: one-cycle pulse; `cipher_text` is valid.
- `cipher_text`, in, DATA_LEN: ciphertext block, in FIPS byte order (MSB = byte 0).
- `key_valid_in`, in, 1: one-cycle pulse; `cipher_key` is valid.
- `cipher_key`, in, KEY_LEN: the cipher key used for encryption (round key 0).
- `ready`, out, 1: high in IDLE, meaning a new request is accepted.
- `data_valid_out`, out, 1: one-cycle pulse; `plain_text` is valid.
- `plain_text`, out, DATA_LEN: decrypted block. Holds until the next result.

## Operation
- Reset values: `ready`=1, `data_valid_out`=0, `plain_text`=0, FSM state=IDLE, round counter=0, key cache invalid.
- States:
  - IDLE: waits for a request.
  - KEXP: forward key expansion. Each cycle computes rk[i] from rk[i-1] with rcon[i], for i = 1..10.
  - ROUND: inverse rounds. The counter r runs 10 down to 1.
- Request accepted in IDLE with `key_valid_in`=1 and `data_valid_in`=1:
  - Latch key and ciphertext; go to KEXP.
  - On the KEXP edge that produces rk10: `state_reg` <= ciphertext ^ rk10 (initial AddRoundKey), key register <= rk10, go to ROUND.
- ROUND, for each r:
  - Apply InvShiftRows, then InvSubBytes, then AddRoundKey(rk[r-1]).
  - Apply InvMixColumns only when r > 1.
  - The key register steps from rk[r] to rk[r-1] by the inverse schedule: w[j] ^= w[j-1] for j = 3..1, then w0 ^= SubWord(RotWord(w3')) ^ rcon[r].
- After r = 1: register the result to `plain_text`, pulse `data_valid_out`, return to IDLE.
- Requests while not IDLE are dropped silently, whether data or key. Nothing is queued.
- `data_valid_in` with `key_valid_in`=0 while no key is available: dropped, and the block stays in IDLE.
- Reset asserted mid-operation: the block aborts with no `data_valid_out`. All state returns to its reset values, including cache invalidation.
- Key schedule byte arithmetic is GF(2^8) with polynomial 0x11B. InvMixColumns uses coefficients {0e,0b,0d,09}.

## Timing
- The request is sampled at edge E0, which is the start of cycle T.
- With a key: KEXP runs cycles T..T+9 and ROUND runs cycles T+10..T+19. `data_valid_out`=1 in cycle T+20, which is 20 cycles after E0.
- Cached key (macro on, data only): ROUND runs cycles T..T+9. `data_valid_out`=1 in cycle T+10.
- `ready` is 0 from cycle T until `data_valid_out` is asserted. It returns to 1 in the same cycle as `data_valid_out`. A new request may be sampled in that cycle.
- `data_valid_out` is exactly one cycle wide.

## Configuration
- `AES_DEC_KEY_CACHE_EN` defined:
  - rk10 is kept after each expansion, and the cache is marked valid.
  - `data_valid_in` alone then skips KEXP, giving a latency of 10.
  - `key_valid_in` alone runs KEXP, refreshes the cache and returns to IDLE with no output (`ready` is low for 10 cycles).
  - Key with data always re-expands.
- `AES_DEC_KEY_CACHE_EN` undefined:
  - There is no cache register.
  - Only simultaneous `key_valid_in` and `data_valid_in` starts an operation.
  - All other requests are dropped.

## Structure
- Package `aes_dec_pkg` holds:
  - forward S-box and inverse S-box constants;
  - the rcon table;
  - the FSM state enum (IDLE/KEXP/ROUND);
  - GF helpers xtime and gmul;
  - width constants.
- Sub-module `aes_inv_round`: combinational, taking state, round key and a `last` flag and producing the next state. It is instantiated once.

## Test plan
- FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c with ciphertext 3925841d02dc09fbdc118597196a0b32.
  - Required: `plain_text` = 3243f6a8885a308d313198a2e0370734, with `data_valid_out` exactly 20 cycles after the sample edge.
- FIPS-197 Appendix C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f with ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: `plain_text` = 00112233445566778899aabbccddeeff.
- Busy drop:
  - Stimulus: pulse a second request 5 cycles after the first.
  - Required: only one `data_valid_out`, carrying the first result, and `ready`=0 during cycles T..T+19.
- Reset mid-operation:
  - Stimulus: assert `reset`=0 at cycle T+12 for 2 cycles, then release.
  - Required: no `data_valid_out`, `plain_text`=0, `ready`=1. A fresh Appendix B request then decrypts correctly.
- Cache (macro on):
  - Stimulus: Appendix B with key, then ciphertext alone.
  - Required: the same plaintext, with `data_valid_out` 10 cycles after the sample edge.
- Cache (macro off):
  - Stimulus: ciphertext alone.
  - Required: no response, and `ready` stays 1.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// +-----------------------------------------------------------------------+
// | aes_dec_pkg : shared constants, tables and GF helpers for AES-128     |
// |               decryption (S-boxes, rcon, state encoding, key steps)   |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
`default_nettype none

package aes_dec_pkg;

   localparam int BLK_W = 128;
   localparam int RND_W = 4;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_KEXP  = 2'd1;
   localparam state_t ST_ROUND = 2'd2;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   localparam logic [7:0] INV_SBOX [0:255] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
   };

   // Indexed by round number; entries past 10 are never selected.
   localparam logic [7:0] RCON [0:15] = '{
      8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,
      8'h80,8'h1b,8'h36,8'h00,8'h00,8'h00,8'h00,8'h00
   };

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w, input logic [7:0] rc);
      return {SBOX[w[23:16]] ^ rc, SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ sub_rot_word(k[31:0], rc);
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n3 = k[31:0] ^ k[63:32];
      n2 = k[63:32] ^ k[95:64];
      n1 = k[95:64] ^ k[127:96];
      n0 = k[127:96] ^ sub_rot_word(n3, rc);
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
              gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
              gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
              gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
   endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_round.sv
// +-----------------------------------------------------------------------+
// | aes_inv_round : one combinational AES inverse round                   |
// |                 (InvShiftRows, InvSubBytes, AddRoundKey, InvMixCols)  |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+
`default_nettype none

module aes_inv_round
   import aes_dec_pkg::*;
(
   input  logic [BLK_W-1:0] state_in,
   input  logic [BLK_W-1:0] round_key,
   input  logic             last,
   output logic [BLK_W-1:0] state_out
);

   logic [BLK_W-1:0] ark;

   // Byte n sits at row n%4, column n/4; row r rotates right by r columns.
   always_comb begin
      ark = '0;
      for (int n = 0; n < 16; n++) begin
         int src;
         src = 4 * (((n / 4) - (n % 4) + 4) % 4) + (n % 4);
         ark[127-8*n -: 8] = INV_SBOX[state_in[127-8*src -: 8]] ^ round_key[127-8*n -: 8];
      end
   end

   always_comb begin
      state_out = ark;
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            state_out[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/aes_inv_cipher.sv
// +-----------------------------------------------------------------------+
// | aes_inv_cipher : iterative AES-128 decryption, one round per clock,   |
// |                  on-the-fly inverse key schedule.                     |
// |                  Optional rk10 cache: define AES_DEC_KEY_CACHE_EN.    |
// | Revision       : 1.0                                                  |
// +-----------------------------------------------------------------------+
`default_nettype none

module aes_inv_cipher
   import aes_dec_pkg::*;
#(
   parameter int KEY_LEN       = 128,
   parameter int DATA_LEN      = 128,
   parameter int NUMS_OF_ROUND = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                data_valid_in,
   input  logic [DATA_LEN-1:0] cipher_text,
   input  logic                key_valid_in,
   input  logic [KEY_LEN-1:0]  cipher_key,
   output logic                ready,
   output logic                data_valid_out,
   output logic [DATA_LEN-1:0] plain_text
);

   localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUMS_OF_ROUND);

   state_t           fsm_q,   fsm_d;
   logic [RND_W-1:0] rnd_q,   rnd_d;
   logic [BLK_W-1:0] key_q,   key_d;
   logic [BLK_W-1:0] state_q, state_d;
   logic [BLK_W-1:0] plain_q, plain_d;
   logic             dv_q,    dv_d;

   logic [BLK_W-1:0] fwd_key;
   logic [BLK_W-1:0] inv_key;
   logic [BLK_W-1:0] round_out;

`ifdef AES_DEC_KEY_CACHE_EN
   logic [BLK_W-1:0] cache_q,     cache_d;
   logic             cache_vld_q, cache_vld_d;
   logic             dec_q,       dec_d;
`endif

   assign fwd_key = key_fwd(key_q, RCON[rnd_q]);
   assign inv_key = key_inv(key_q, RCON[rnd_q]);

   aes_inv_round u_round (
      .state_in  (state_q),
      .round_key (inv_key),
      .last      (rnd_q == 4'd1),
      .state_out (round_out)
   );

   always_comb begin
      fsm_d   = fsm_q;
      rnd_d   = rnd_q;
      key_d   = key_q;
      state_d = state_q;
      plain_d = plain_q;
      dv_d    = 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_d     = cache_q;
      cache_vld_d = cache_vld_q;
      dec_d       = dec_q;
`endif
      case (fsm_q)
         ST_IDLE: begin
            if (key_valid_in && data_valid_in) begin
               key_d   = cipher_key;
               state_d = cipher_text;
               rnd_d   = 4'd1;
               fsm_d   = ST_KEXP;
`ifdef AES_DEC_KEY_CACHE_EN
               dec_d   = 1'b1;
            end else if (key_valid_in) begin
               key_d   = cipher_key;
               rnd_d   = 4'd1;
               fsm_d   = ST_KEXP;
               dec_d   = 1'b0;
            end else if (data_valid_in && cache_vld_q) begin
               // Initial AddRoundKey folds into acceptance; rounds start at once.
               key_d   = cache_q;
               state_d = cipher_text ^ cache_q;
               rnd_d   = LAST_RND;
               fsm_d   = ST_ROUND;
`endif
            end
         end
         ST_KEXP: begin
            key_d = fwd_key;
            if (rnd_q == LAST_RND) begin
`ifdef AES_DEC_KEY_CACHE_EN
               cache_d     = fwd_key;
               cache_vld_d = 1'b1;
               if (dec_q) begin
                  state_d = state_q ^ fwd_key;
                  fsm_d   = ST_ROUND;
               end else begin
                  rnd_d   = '0;
                  fsm_d   = ST_IDLE;
               end
`else
               state_d = state_q ^ fwd_key;
               fsm_d   = ST_ROUND;
`endif
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         ST_ROUND: begin
            key_d   = inv_key;
            state_d = round_out;
            if (rnd_q == 4'd1) begin
               plain_d = round_out;
               dv_d    = 1'b1;
               rnd_d   = '0;
               fsm_d   = ST_IDLE;
            end else begin
               rnd_d = rnd_q - 4'd1;
            end
         end
         default: begin
            fsm_d = ST_IDLE;
            rnd_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fsm_q   <= ST_IDLE;
         rnd_q   <= '0;
         key_q   <= '0;
         state_q <= '0;
         plain_q <= '0;
         dv_q    <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         rnd_q   <= rnd_d;
         key_q   <= key_d;
         state_q <= state_d;
         plain_q <= plain_d;
         dv_q    <= dv_d;
      end
   end

`ifdef AES_DEC_KEY_CACHE_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         cache_q     <= '0;
         cache_vld_q <= 1'b0;
         dec_q       <= 1'b0;
      end else begin
         cache_q     <= cache_d;
         cache_vld_q <= cache_vld_d;
         dec_q       <= dec_d;
      end
   end
`endif

   assign ready          = (fsm_q == ST_IDLE);
   assign data_valid_out = dv_q;
   assign plain_text     = plain_q;

endmodule

`default_nettype wire
